// File: rtl/controlador_registrador7b_if.sv
// Purpose : bundles the control handshake between the user-control FSM and the
//           shift-register sequencer (requests in, register control lines and status out).
// Ports   : iniciar/pausar/cancelar (requests), ch1/ch0/sinal (register cell control),
//           ocupado/concluido/contagem (status). master = requester side, slave = sequencer.
interface controlador_registrador7b_if #(
  parameter int CW = 3
);
  logic          iniciar;
  logic          pausar;
  logic          cancelar;
  logic          ch1;
  logic          ch0;
  logic          sinal;
  logic          ocupado;
  logic          concluido;
  logic [CW-1:0] contagem;

  modport master (
    output iniciar, pausar, cancelar,
    input  ch1, ch0, sinal, ocupado, concluido, contagem
  );

  modport slave (
    input  iniciar, pausar, cancelar,
    output ch1, ch0, sinal, ocupado, concluido, contagem
  );
endinterface

// File: rtl/controlador_registrador7b.sv
// Purpose : sequences the 7-bit shift register: one parallel load, then N_BITS shift
//           strobes, one every DIVISOR cycles, with pause/cancel and busy/done status.
// Ports   : clk, reset (async, active-high); bus (slave modport): iniciar, pausar,
//           cancelar in; ch1/ch0 mode select, sinal path enable, ocupado, concluido, contagem out.
//           Outputs are a pure decode of registered state (no input-to-output path).
module controlador_registrador7b #(
  parameter int N_BITS  = 7,
  parameter int DIVISOR = 4,
  parameter int CW      = $clog2(N_BITS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  controlador_registrador7b_if.slave  bus
);

  // Prescaler needs at least one bit even when DIVISOR == 1.
  localparam int PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(DIVISOR - 1);
  localparam logic [CW-1:0] C_LAST = CW'(N_BITS - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    CARREGA,
    DESLOCA,
    PAUSADO,
    CONCLUIDO
  } estado_t;

  estado_t       r_estado;
  estado_t       w_prox;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_prox;
  logic [CW-1:0] r_cont;
  logic [CW-1:0] w_cont_prox;
  logic          w_strobe;
  logic          w_carga;

  assign w_strobe = (r_estado == DESLOCA) && (r_presc == P_LAST);
  assign w_carga  = (r_estado == CARREGA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado <= OCIOSO;
      r_presc  <= '0;
      r_cont   <= '0;
    end else begin
      r_estado <= w_prox;
      r_presc  <= w_presc_prox;
      r_cont   <= w_cont_prox;
    end
  end

  always_comb begin
    w_prox       = r_estado;
    w_presc_prox = r_presc;
    w_cont_prox  = r_cont;
    case (r_estado)
      OCIOSO: begin
        // cancel wins over a simultaneous start request
        if (bus.iniciar && !bus.cancelar) begin
          w_prox = CARREGA;
        end
      end
      CARREGA: begin
        if (bus.cancelar) begin
          w_prox = OCIOSO;
        end else begin
          w_prox       = DESLOCA;
          w_presc_prox = '0;
          w_cont_prox  = '0;
        end
      end
      DESLOCA: begin
        // A strobe cycle already drove sinal=1, so the register shifted on this
        // edge whatever else happens; count it even when cancelling.
        if (w_strobe) begin
          w_cont_prox = r_cont + CW'(1);
        end
        if (bus.cancelar) begin
          w_prox = OCIOSO;
        end else if (w_strobe && (r_cont == C_LAST)) begin
          w_prox = CONCLUIDO;
        end else begin
          w_presc_prox = (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
          w_prox       = bus.pausar ? PAUSADO : DESLOCA;
        end
      end
      PAUSADO: begin
        if (bus.cancelar) begin
          w_prox = OCIOSO;
        end else if (!bus.pausar) begin
          w_prox = DESLOCA;
        end
      end
      CONCLUIDO: begin
        w_prox = OCIOSO;
      end
      default: begin
        w_prox = OCIOSO;
      end
    endcase
  end

  // Mode 10 = load, 01 = shift, 00 = hold; 11 cannot occur since load and
  // strobe decode from different states.
  assign bus.ch1       = w_carga;
  assign bus.ch0       = w_strobe;
  assign bus.sinal     = w_carga | w_strobe;
  assign bus.ocupado   = (r_estado != OCIOSO);
  assign bus.concluido = (r_estado == CONCLUIDO);
  assign bus.contagem  = r_cont;

endmodule
